minisrc_ctrl_seq: RTL and testbench
===================================

// Module: minisrc_ctrl_seq
// PURPOSE
//  Hardwired control sequencer for the MiniSRC datapath; replaces the bench-driven T-state control.
//  Decodes IR[31:27], steps T0..T7 per instruction and drives every datapath control strobe.
//  Adds memory wait states, a halt state and a run/step status. Sits beside DataPath, same Clock.
// PARAMETERS
//  DATA_W     32  IR width
//  OPC_LSB    27  LSB of 5-bit opcode field in IR
//  MAX_STEP   7   last T-state index; an opcode whose last step is below MAX_STEP ends early
//  WAIT_MAX   15  memory wait cycles before MemErr; 4-bit wait counter
// PORTS
//  Clock      in   1      rising-edge clock
//  Clear      in   1      synchronous reset, active-high
//  IR         in   DATA_W instruction register contents (valid from T3)
//  CON        in   1      branch condition flip-flop output
//  MemReady   in   1      memory read/write complete this cycle
//  StepEn     in   1      single-step advance pulse (SINGLE_STEP_EN only; ignored otherwise)
//  BusSel     out  9      one-hot bus source {InPortOut,Cout,Rout,LOout,HIout,MDRout,Zhighout,Zlowout,PCout}
//  LoadEn     out  11     {OutPortIn,CONin,Rin,LOin,HIin,Yin,IRin,MDRin,PCin,Zin,MARin}
//  RegSel     out  4      {BAout,Grc,Grb,Gra}
//  AluOp      out  4      encoded ALU op (pkg ALU_*); ALU_NOP=0
//  IncPC, Read, Write out 1 each
//  Run        out  1      high while fetching/executing; low in RESET/HALT
//  TState     out  4      current step; 4'hF in RESET, 4'hE in HALT
//  MemErr     out  1      sticky; set when a wait exceeds WAIT_MAX
// BEHAVIOUR
//  Reset (Clear=1 at edge): state RESET, all outputs 0, TState=4'hF, MemErr=0, wait ctr=0.
//   Clear overrides any state including mid-wait and HALT. RESET -> T0 next cycle.
//  All outputs are Moore-decoded from {state,opcode}; registered opcode latched at end of T2.
//  Fetch, all ops: T0 PCout,MARin,IncPC,Zin | T1 Zlowout,PCin,Read,MDRin | T2 MDRout,IRin.
//  Wait: in any step asserting Read or Write, state holds while MemReady=0; strobes held stable.
//   Wait ctr counts held cycles; at WAIT_MAX with MemReady=0 -> MemErr=1, state -> HALT.
//   MemReady=1 on first cycle of step = zero wait states.
//  Execute classes (T3..):
//   ld/ldi/st: T3 Grb,BAout,Yin | T4 Cout,ALU_ADD,Zin | ld/st T5 Zlowout,MARin;
//     ld T6 Read,MDRin | T7 MDRout,Gra,Rin; ldi T5 Zlowout,Gra,Rin; st T6 Gra,Rout,Write.
//   R-type add..rol: T3 Grb,Rout,Yin | T4 Grc,Rout,op,Zin | T5 Zlowout,Gra,Rin.
//   addi/andi/ori: as R-type with T4 Cout instead of Grc,Rout.
//   mul/div: T3 Gra,Rout,Yin | T4 Grb,Rout,op,Zin | T5 Zlowout,LOin | T6 Zhighout,HIin.
//   neg/not: T3 Grb,Rout,op,Zin | T4 Zlowout,Gra,Rin.
//   br: T3 Gra,Rout,CONin | T4 PCout,Yin | T5 Cout,ALU_ADD,Zin | T6 Zlowout,PCin only if CON=1.
//   jr: T3 Gra,Rout,PCin. jal: T3 PCout,Grb,Rin (R15 via Grb field) | T4 Gra,Rout,PCin.
//   in: T3 InPortOut,Gra,Rin. out: T3 Gra,Rout,OutPortIn. mfhi/mflo: T3 HIout|LOout,Gra,Rin.
//   nop: ends at T2. halt: state -> HALT after T2; HALT exits only on Clear.
//  After last step of an op, next state is T0 (no idle cycle). Unknown opcode = nop.
//  Invariant: BusSel popcount <= 1 every cycle; Read and Write never both 1.
// CONFIGURATION
//  SINGLE_STEP_EN defined: state advances only on cycles with StepEn=1 (wait rule still applies,
//   strobes held between steps, Zin/Read edges still one per step). Undefined: free-running.
// STRUCTURE
//  Package minisrc_ctrl_pkg: opcode constants (ld=0,ldi=1,st=2,add=3,sub=4,and=5,or=6,shr=7,
//   shra=8,shl=9,ror=10,rol=11,addi=12,andi=13,ori=14,mul=15,div=16,neg=17,not=18,br=19,jr=20,
//   jal=21,in=22,out=23,mfhi=24,mflo=25,nop=26,halt=27), ALU_* codes, state codes, BusSel/LoadEn bit indices.
//  Sub-module minisrc_ctrl_decode: combinational {state,opcode,CON} -> strobes; top holds state, wait ctr.
// TESTING
//  ldi R2,0x55 (IR=0x0910_0055), MemReady=1 -> fetch T0..T2, T5 Zlowout+Gra+Rin, next T0 at cycle 6.
//  ld with MemReady low 3 cycles in T6 -> T6 held 4 cycles, Read/MDRin stable, then T7; MemErr=0.
//  MemReady held 0 in T1 -> after 15 waits MemErr=1, TState=4'hE, Run=0; Clear -> TState=4'hF.
//  br with CON=0 vs CON=1 -> PCin in T6 absent vs present; both next T0.
//  mul -> LOin at T5, HIin at T6; BusSel one-hot checked every cycle over 200 random opcodes.
//  Clear asserted mid-T4 of add -> next cycle all outputs 0, then T0; SINGLE_STEP_EN build: T-state moves only on StepEn.

Source files
------------

// File: rtl/minisrc_ctrl_seq_pkg.sv
// minisrc_ctrl_pkg: shared constants and helpers for the MiniSRC control sequencer.
// Contents: sizing localparams, step/state encoding, opcode values, ALU op codes,
// bit positions inside the BusSel / LoadEn / RegSel strobe vectors, and two
// per-opcode helpers (ALU op select, last execute step).
package minisrc_ctrl_pkg;

    localparam int DATA_W   = 32;
    localparam int OPC_LSB  = 27;
    localparam int MAX_STEP = 7;
    localparam int WAIT_MAX = 15;

    // State code doubles as the TState debug value: T-steps are their own index.
    typedef enum logic [3:0] {
        ST_T0    = 4'd0,
        ST_T1    = 4'd1,
        ST_T2    = 4'd2,
        ST_T3    = 4'd3,
        ST_T4    = 4'd4,
        ST_T5    = 4'd5,
        ST_T6    = 4'd6,
        ST_T7    = 4'd7,
        ST_HALT  = 4'hE,
        ST_RESET = 4'hF
    } state_t;

    typedef logic [4:0] opc_t;

    localparam opc_t OP_LD   = 5'd0;
    localparam opc_t OP_LDI  = 5'd1;
    localparam opc_t OP_ST   = 5'd2;
    localparam opc_t OP_ADD  = 5'd3;
    localparam opc_t OP_SUB  = 5'd4;
    localparam opc_t OP_AND  = 5'd5;
    localparam opc_t OP_OR   = 5'd6;
    localparam opc_t OP_SHR  = 5'd7;
    localparam opc_t OP_SHRA = 5'd8;
    localparam opc_t OP_SHL  = 5'd9;
    localparam opc_t OP_ROR  = 5'd10;
    localparam opc_t OP_ROL  = 5'd11;
    localparam opc_t OP_ADDI = 5'd12;
    localparam opc_t OP_ANDI = 5'd13;
    localparam opc_t OP_ORI  = 5'd14;
    localparam opc_t OP_MUL  = 5'd15;
    localparam opc_t OP_DIV  = 5'd16;
    localparam opc_t OP_NEG  = 5'd17;
    localparam opc_t OP_NOT  = 5'd18;
    localparam opc_t OP_BR   = 5'd19;
    localparam opc_t OP_JR   = 5'd20;
    localparam opc_t OP_JAL  = 5'd21;
    localparam opc_t OP_IN   = 5'd22;
    localparam opc_t OP_OUT  = 5'd23;
    localparam opc_t OP_MFHI = 5'd24;
    localparam opc_t OP_MFLO = 5'd25;
    localparam opc_t OP_NOP  = 5'd26;
    localparam opc_t OP_HALT = 5'd27;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_SHR  = 4'd5;
    localparam logic [3:0] ALU_SHRA = 4'd6;
    localparam logic [3:0] ALU_SHL  = 4'd7;
    localparam logic [3:0] ALU_ROR  = 4'd8;
    localparam logic [3:0] ALU_ROL  = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;
    localparam logic [3:0] ALU_DIV  = 4'd11;
    localparam logic [3:0] ALU_NEG  = 4'd12;
    localparam logic [3:0] ALU_NOT  = 4'd13;

    // BusSel bit positions (one-hot bus source)
    localparam int B_PC  = 0;
    localparam int B_ZLO = 1;
    localparam int B_ZHI = 2;
    localparam int B_MDR = 3;
    localparam int B_HI  = 4;
    localparam int B_LO  = 5;
    localparam int B_R   = 6;
    localparam int B_C   = 7;
    localparam int B_INP = 8;

    // LoadEn bit positions
    localparam int L_MAR  = 0;
    localparam int L_Z    = 1;
    localparam int L_PC   = 2;
    localparam int L_MDR  = 3;
    localparam int L_IR   = 4;
    localparam int L_Y    = 5;
    localparam int L_HI   = 6;
    localparam int L_LO   = 7;
    localparam int L_R    = 8;
    localparam int L_CON  = 9;
    localparam int L_OUTP = 10;

    // RegSel bit positions
    localparam int R_GRA = 0;
    localparam int R_GRB = 1;
    localparam int R_GRC = 2;
    localparam int R_BA  = 3;

    function automatic logic [3:0] alu_of(input opc_t op);
        logic [3:0] a;
        a = ALU_NOP;
        case (op)
            OP_ADD, OP_ADDI: a = ALU_ADD;
            OP_SUB:          a = ALU_SUB;
            OP_AND, OP_ANDI: a = ALU_AND;
            OP_OR,  OP_ORI:  a = ALU_OR;
            OP_SHR:          a = ALU_SHR;
            OP_SHRA:         a = ALU_SHRA;
            OP_SHL:          a = ALU_SHL;
            OP_ROR:          a = ALU_ROR;
            OP_ROL:          a = ALU_ROL;
            OP_MUL:          a = ALU_MUL;
            OP_DIV:          a = ALU_DIV;
            OP_NEG:          a = ALU_NEG;
            OP_NOT:          a = ALU_NOT;
            default:         a = ALU_NOP;
        endcase
        return a;
    endfunction

    // Index of the final T-step for each opcode; unknown opcodes behave as nop.
    function automatic logic [2:0] last_step(input opc_t op);
        logic [2:0] s;
        s = 3'd2;
        case (op)
            OP_LD:                                       s = 3'(MAX_STEP);
            OP_LDI:                                      s = 3'd5;
            OP_ST, OP_MUL, OP_DIV, OP_BR:                s = 3'd6;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
            OP_ADDI, OP_ANDI, OP_ORI:                    s = 3'd5;
            OP_NEG, OP_NOT, OP_JAL:                      s = 3'd4;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:      s = 3'd3;
            default:                                     s = 3'd2;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/minisrc_ctrl_seq_if.sv
// minisrc_ctrl_seq_if: signal bundle between the control sequencer and the MiniSRC datapath.
// master modport = sequencer (drives strobes/status, samples IR/CON/MemReady/StepEn).
// slave modport  = datapath/memory side (the reverse).
// Memory handshake: while a step holds Read or Write high, that strobe is the request;
// the access completes on the cycle MemReady=1 is seen, and only then does the step advance.
interface minisrc_ctrl_seq_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] IR;
    logic              CON;
    logic              MemReady;
    logic              StepEn;
    logic [8:0]        BusSel;
    logic [10:0]       LoadEn;
    logic [3:0]        RegSel;
    logic [3:0]        AluOp;
    logic              IncPC;
    logic              Read;
    logic              Write;
    logic              Run;
    logic [3:0]        TState;
    logic              MemErr;

    modport master (
        input  IR, CON, MemReady, StepEn,
        output BusSel, LoadEn, RegSel, AluOp, IncPC, Read, Write, Run, TState, MemErr
    );

    modport slave (
        output IR, CON, MemReady, StepEn,
        input  BusSel, LoadEn, RegSel, AluOp, IncPC, Read, Write, Run, TState, MemErr
    );
endinterface

// File: rtl/minisrc_ctrl_seq_decode.sv
// minisrc_ctrl_seq_decode: combinational strobe decoder for the MiniSRC sequencer.
// Ports: i_state (current step), i_opc (opcode in effect), i_con (branch flag)
//   -> o_bus_sel, o_load_en, o_reg_sel, o_alu_op, o_inc_pc, o_read, o_write.
// RESET and HALT decode to all-zero strobes.
import minisrc_ctrl_pkg::*;

module minisrc_ctrl_seq_decode (
    input  state_t      i_state,
    input  opc_t        i_opc,
    input  logic        i_con,
    output logic [8:0]  o_bus_sel,
    output logic [10:0] o_load_en,
    output logic [3:0]  o_reg_sel,
    output logic [3:0]  o_alu_op,
    output logic        o_inc_pc,
    output logic        o_read,
    output logic        o_write
);
    always_comb begin
        o_bus_sel = '0;
        o_load_en = '0;
        o_reg_sel = '0;
        o_alu_op  = ALU_NOP;
        o_inc_pc  = 1'b0;
        o_read    = 1'b0;
        o_write   = 1'b0;
        case (i_state)
            ST_T0: begin
                o_bus_sel[B_PC] = 1'b1; o_load_en[L_MAR] = 1'b1;
                o_load_en[L_Z]  = 1'b1; o_inc_pc = 1'b1;
            end
            ST_T1: begin
                o_bus_sel[B_ZLO] = 1'b1; o_load_en[L_PC] = 1'b1;
                o_load_en[L_MDR] = 1'b1; o_read = 1'b1;
            end
            ST_T2: begin
                o_bus_sel[B_MDR] = 1'b1; o_load_en[L_IR] = 1'b1;
            end
            ST_T3: begin
                case (i_opc)
                    OP_LD, OP_LDI, OP_ST: begin
                        o_reg_sel[R_GRB] = 1'b1; o_reg_sel[R_BA] = 1'b1; o_load_en[L_Y] = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        o_reg_sel[R_GRB] = 1'b1; o_bus_sel[B_R] = 1'b1; o_load_en[L_Y] = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        o_reg_sel[R_GRA] = 1'b1; o_bus_sel[B_R] = 1'b1; o_load_en[L_Y] = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin
                        o_reg_sel[R_GRB] = 1'b1; o_bus_sel[B_R] = 1'b1;
                        o_alu_op = alu_of(i_opc); o_load_en[L_Z] = 1'b1;
                    end
                    OP_BR: begin
                        o_reg_sel[R_GRA] = 1'b1; o_bus_sel[B_R] = 1'b1; o_load_en[L_CON] = 1'b1;
                    end
                    OP_JR: begin
                        o_reg_sel[R_GRA] = 1'b1; o_bus_sel[B_R] = 1'b1; o_load_en[L_PC] = 1'b1;
                    end
                    OP_JAL: begin
                        // Return address goes to R15, addressed through the Rb field.
                        o_bus_sel[B_PC] = 1'b1; o_reg_sel[R_GRB] = 1'b1; o_load_en[L_R] = 1'b1;
                    end
                    OP_IN: begin
                        o_bus_sel[B_INP] = 1'b1; o_reg_sel[R_GRA] = 1'b1; o_load_en[L_R] = 1'b1;
                    end
                    OP_OUT: begin
                        o_reg_sel[R_GRA] = 1'b1; o_bus_sel[B_R] = 1'b1; o_load_en[L_OUTP] = 1'b1;
                    end
                    OP_MFHI: begin
                        o_bus_sel[B_HI] = 1'b1; o_reg_sel[R_GRA] = 1'b1; o_load_en[L_R] = 1'b1;
                    end
                    OP_MFLO: begin
                        o_bus_sel[B_LO] = 1'b1; o_reg_sel[R_GRA] = 1'b1; o_load_en[L_R] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (i_opc)
                    OP_LD, OP_LDI, OP_ST: begin
                        o_bus_sel[B_C] = 1'b1; o_alu_op = ALU_ADD; o_load_en[L_Z] = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL: begin
                        o_reg_sel[R_GRC] = 1'b1; o_bus_sel[B_R] = 1'b1;
                        o_alu_op = alu_of(i_opc); o_load_en[L_Z] = 1'b1;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        o_bus_sel[B_C] = 1'b1; o_alu_op = alu_of(i_opc); o_load_en[L_Z] = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        o_reg_sel[R_GRB] = 1'b1; o_bus_sel[B_R] = 1'b1;
                        o_alu_op = alu_of(i_opc); o_load_en[L_Z] = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin
                        o_bus_sel[B_ZLO] = 1'b1; o_reg_sel[R_GRA] = 1'b1; o_load_en[L_R] = 1'b1;
                    end
                    OP_BR: begin
                        o_bus_sel[B_PC] = 1'b1; o_load_en[L_Y] = 1'b1;
                    end
                    OP_JAL: begin
                        o_reg_sel[R_GRA] = 1'b1; o_bus_sel[B_R] = 1'b1; o_load_en[L_PC] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (i_opc)
                    OP_LD, OP_ST: begin
                        o_bus_sel[B_ZLO] = 1'b1; o_load_en[L_MAR] = 1'b1;
                    end
                    OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR,
                    OP_ROL, OP_ADDI, OP_ANDI, OP_ORI: begin
                        o_bus_sel[B_ZLO] = 1'b1; o_reg_sel[R_GRA] = 1'b1; o_load_en[L_R] = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        o_bus_sel[B_ZLO] = 1'b1; o_load_en[L_LO] = 1'b1;
                    end
                    OP_BR: begin
                        o_bus_sel[B_C] = 1'b1; o_alu_op = ALU_ADD; o_load_en[L_Z] = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (i_opc)
                    OP_LD: begin
                        o_read = 1'b1; o_load_en[L_MDR] = 1'b1;
                    end
                    OP_ST: begin
                        o_reg_sel[R_GRA] = 1'b1; o_bus_sel[B_R] = 1'b1; o_write = 1'b1;
                    end
                    OP_MUL, OP_DIV: begin
                        o_bus_sel[B_ZHI] = 1'b1; o_load_en[L_HI] = 1'b1;
                    end
                    OP_BR: begin
                        // Branch target is committed only when the condition flop is set.
                        if (i_con) begin
                            o_bus_sel[B_ZLO] = 1'b1; o_load_en[L_PC] = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                if (i_opc == OP_LD) begin
                    o_bus_sel[B_MDR] = 1'b1; o_reg_sel[R_GRA] = 1'b1; o_load_en[L_R] = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/minisrc_ctrl_seq.sv
// minisrc_ctrl_seq: hardwired T-state control sequencer for the MiniSRC datapath.
// Ports: Clock, Clear (sync, active-high) and bus (minisrc_ctrl_seq_if.master):
//   in  IR, CON, MemReady, StepEn
//   out BusSel, LoadEn, RegSel, AluOp, IncPC, Read, Write, Run, TState, MemErr
// Build option: define SINGLE_STEP_EN to advance steps only on StepEn=1 cycles;
// without it the sequencer free-runs and StepEn is ignored.
// Holds the step state, memory wait counter, sticky MemErr and the latched opcode;
// all strobes come from minisrc_ctrl_seq_decode.
import minisrc_ctrl_pkg::*;

module minisrc_ctrl_seq #(
    parameter int DATA_W  = minisrc_ctrl_pkg::DATA_W,
    parameter int OPC_LSB = minisrc_ctrl_pkg::OPC_LSB
) (
    input  logic                 Clock,
    input  logic                 Clear,
    minisrc_ctrl_seq_if.master   bus
);
    state_t     r_state, w_state_nxt;
    logic [3:0] r_wait,  w_wait_nxt;
    logic       r_err,   w_err_nxt;
    opc_t       r_opc;

    opc_t        w_ir_opc, w_opc;
    logic [2:0]  w_last;
    logic        w_adv;
    logic        w_mem_busy;
    logic [8:0]  w_bus_sel;
    logic [10:0] w_load_en;
    logic [3:0]  w_reg_sel, w_alu_op;
    logic        w_inc_pc, w_read, w_write;
    logic        w_unused_bits;

    assign w_ir_opc = bus.IR[OPC_LSB +: 5];
    // During T2 the new IR is already presented, so the end-of-fetch decision
    // (nop/halt finish at T2) uses it directly; later steps use the latched copy.
    assign w_opc  = (r_state == ST_T2) ? w_ir_opc : r_opc;
    assign w_last = last_step(w_opc);
    assign w_unused_bits = ^{bus.IR, bus.StepEn};

`ifdef SINGLE_STEP_EN
    assign w_adv = bus.StepEn;
`else
    assign w_adv = 1'b1;
`endif

    assign w_mem_busy = w_read | w_write;

    minisrc_ctrl_seq_decode u_decode (
        .i_state   (r_state),
        .i_opc     (w_opc),
        .i_con     (bus.CON),
        .o_bus_sel (w_bus_sel),
        .o_load_en (w_load_en),
        .o_reg_sel (w_reg_sel),
        .o_alu_op  (w_alu_op),
        .o_inc_pc  (w_inc_pc),
        .o_read    (w_read),
        .o_write   (w_write)
    );

    always_ff @(posedge Clock) begin
        if (Clear) begin
            r_state <= ST_RESET;
            r_wait  <= 4'd0;
            r_err   <= 1'b0;
            r_opc   <= OP_NOP;
        end else begin
            r_state <= w_state_nxt;
            r_wait  <= w_wait_nxt;
            r_err   <= w_err_nxt;
            if (r_state == ST_T2) begin
                r_opc <= w_ir_opc;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wait_nxt  = r_wait;
        w_err_nxt   = r_err;
        case (r_state)
            ST_RESET: begin
                if (w_adv) w_state_nxt = ST_T0;
            end
            ST_HALT: ;
            default: begin
                if (w_mem_busy && !bus.MemReady) begin
                    // Access still pending: hold the step; give up after WAIT_MAX held cycles.
                    if (r_wait == 4'(WAIT_MAX)) begin
                        w_state_nxt = ST_HALT;
                        w_err_nxt   = 1'b1;
                        w_wait_nxt  = 4'd0;
                    end else begin
                        w_wait_nxt = r_wait + 4'd1;
                    end
                end else if (w_adv) begin
                    w_wait_nxt = 4'd0;
                    if (r_state[2:0] == w_last) begin
                        w_state_nxt = (w_opc == OP_HALT) ? ST_HALT : ST_T0;
                    end else begin
                        w_state_nxt = state_t'({1'b0, r_state[2:0] + 3'd1});
                    end
                end
            end
        endcase
    end

    assign bus.BusSel = w_bus_sel;
    assign bus.LoadEn = w_load_en;
    assign bus.RegSel = w_reg_sel;
    assign bus.AluOp  = w_alu_op;
    assign bus.IncPC  = w_inc_pc;
    assign bus.Read   = w_read;
    assign bus.Write  = w_write;
    assign bus.Run    = (r_state != ST_RESET) && (r_state != ST_HALT);
    assign bus.TState = r_state;
    assign bus.MemErr = r_err;
endmodule

// File: tb/tb_minisrc_ctrl_seq.sv
// Directed bench for minisrc_ctrl_seq: per-cycle vector table for several
// instruction classes, then hand sequences for memory timeout, halt, mid-step
// Clear and a run of random opcodes checking step counts and bus exclusivity.
module tb_minisrc_ctrl_seq;

  logic Clock = 1'b0;
  logic Clear = 1'b1;

  minisrc_ctrl_seq_if #(.DATA_W(32)) bus ();

  minisrc_ctrl_seq dut (
    .Clock (Clock),
    .Clear (Clear),
    .bus   (bus)
  );

  // clock / watchdog
  always #5 Clock = ~Clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // packed observation: {TState, BusSel, LoadEn, RegSel, AluOp, IncPC, Read, Write, Run, MemErr}
  typedef struct {
    logic [31:0] ir;
    logic        con;
    logic        mrdy;
    logic [36:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [36:0] exp_q[$];
  int n_checks = 0;
  int n_err    = 0;

  function automatic logic [36:0] obs();
    return {bus.TState, bus.BusSel, bus.LoadEn, bus.RegSel, bus.AluOp,
            bus.IncPC, bus.Read, bus.Write, bus.Run, bus.MemErr};
  endfunction

  task automatic check(input string name, input logic [36:0] act, input logic [36:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  task automatic add_row(input logic [31:0] ir, input logic con, input logic mrdy,
                         input logic [3:0] ts, input logic [8:0] bs, input logic [10:0] le,
                         input logic [3:0] rs, input logic [3:0] alu, input logic [2:0] irw);
    vec_t v;
    v.ir   = ir;
    v.con  = con;
    v.mrdy = mrdy;
    v.exp  = {ts, bs, le, rs, alu, irw, 1'b1, 1'b0};
    vecs.push_back(v);
  endtask

  task automatic add_fetch(input logic [31:0] ir, input logic con);
    add_row(ir, con, 1'b1, 4'd0, 9'h001, 11'h003, 4'h0, 4'd0, 3'b100);
    add_row(ir, con, 1'b1, 4'd1, 9'h002, 11'h00C, 4'h0, 4'd0, 3'b010);
    add_row(ir, con, 1'b1, 4'd2, 9'h008, 11'h010, 4'h0, 4'd0, 3'b000);
  endtask

  // independent step-count table (cycles from T0 to last step inclusive)
  function automatic int exp_len(input logic [4:0] op);
    case (op)
      5'd0:                      return 8;
      5'd1:                      return 6;
      5'd2, 5'd15, 5'd16, 5'd19: return 7;
      5'd17, 5'd18, 5'd21:       return 5;
      5'd20, 5'd22, 5'd23, 5'd24, 5'd25: return 4;
      default: begin
        if (op >= 5'd3 && op <= 5'd14) return 6;
        return 3;
      end
    endcase
  endfunction

  task automatic drive(input logic [31:0] ir, input logic con, input logic mrdy);
    bus.IR       = ir;
    bus.CON      = con;
    bus.MemReady = mrdy;
  endtask

  logic [4:0]  r_op;
  int          len;
  int          viol;
  logic [3:0]  ts_hold;

  initial begin
    bus.IR       = 32'h0;
    bus.CON      = 1'b0;
    bus.MemReady = 1'b1;
    bus.StepEn   = 1'b1;

    // ldi R2,0x55
    add_fetch(32'h0910_0055, 1'b0);
    add_row(32'h0910_0055, 1'b0, 1'b1, 4'd3, 9'h000, 11'h020, 4'hA, 4'd0, 3'b000);
    add_row(32'h0910_0055, 1'b0, 1'b1, 4'd4, 9'h080, 11'h002, 4'h0, 4'd1, 3'b000);
    add_row(32'h0910_0055, 1'b0, 1'b1, 4'd5, 9'h002, 11'h100, 4'h1, 4'd0, 3'b000);
    // sub
    add_fetch(32'h2000_0000, 1'b0);
    add_row(32'h2000_0000, 1'b0, 1'b1, 4'd3, 9'h040, 11'h020, 4'h2, 4'd0, 3'b000);
    add_row(32'h2000_0000, 1'b0, 1'b1, 4'd4, 9'h040, 11'h002, 4'h4, 4'd2, 3'b000);
    add_row(32'h2000_0000, 1'b0, 1'b1, 4'd5, 9'h002, 11'h100, 4'h1, 4'd0, 3'b000);
    // ld with three wait cycles in T6
    add_fetch(32'h0000_0000, 1'b0);
    add_row(32'h0000_0000, 1'b0, 1'b1, 4'd3, 9'h000, 11'h020, 4'hA, 4'd0, 3'b000);
    add_row(32'h0000_0000, 1'b0, 1'b1, 4'd4, 9'h080, 11'h002, 4'h0, 4'd1, 3'b000);
    add_row(32'h0000_0000, 1'b0, 1'b1, 4'd5, 9'h002, 11'h001, 4'h0, 4'd0, 3'b000);
    add_row(32'h0000_0000, 1'b0, 1'b0, 4'd6, 9'h000, 11'h008, 4'h0, 4'd0, 3'b010);
    add_row(32'h0000_0000, 1'b0, 1'b0, 4'd6, 9'h000, 11'h008, 4'h0, 4'd0, 3'b010);
    add_row(32'h0000_0000, 1'b0, 1'b0, 4'd6, 9'h000, 11'h008, 4'h0, 4'd0, 3'b010);
    add_row(32'h0000_0000, 1'b0, 1'b1, 4'd6, 9'h000, 11'h008, 4'h0, 4'd0, 3'b010);
    add_row(32'h0000_0000, 1'b0, 1'b1, 4'd7, 9'h008, 11'h100, 4'h1, 4'd0, 3'b000);
    // st
    add_fetch(32'h1000_0000, 1'b0);
    add_row(32'h1000_0000, 1'b0, 1'b1, 4'd3, 9'h000, 11'h020, 4'hA, 4'd0, 3'b000);
    add_row(32'h1000_0000, 1'b0, 1'b1, 4'd4, 9'h080, 11'h002, 4'h0, 4'd1, 3'b000);
    add_row(32'h1000_0000, 1'b0, 1'b1, 4'd5, 9'h002, 11'h001, 4'h0, 4'd0, 3'b000);
    add_row(32'h1000_0000, 1'b0, 1'b1, 4'd6, 9'h040, 11'h000, 4'h1, 4'd0, 3'b001);
    // br, CON=0
    add_fetch(32'h9800_0000, 1'b0);
    add_row(32'h9800_0000, 1'b0, 1'b1, 4'd3, 9'h040, 11'h200, 4'h1, 4'd0, 3'b000);
    add_row(32'h9800_0000, 1'b0, 1'b1, 4'd4, 9'h001, 11'h020, 4'h0, 4'd0, 3'b000);
    add_row(32'h9800_0000, 1'b0, 1'b1, 4'd5, 9'h080, 11'h002, 4'h0, 4'd1, 3'b000);
    add_row(32'h9800_0000, 1'b0, 1'b1, 4'd6, 9'h000, 11'h000, 4'h0, 4'd0, 3'b000);
    // br, CON=1
    add_fetch(32'h9800_0000, 1'b1);
    add_row(32'h9800_0000, 1'b1, 1'b1, 4'd3, 9'h040, 11'h200, 4'h1, 4'd0, 3'b000);
    add_row(32'h9800_0000, 1'b1, 1'b1, 4'd4, 9'h001, 11'h020, 4'h0, 4'd0, 3'b000);
    add_row(32'h9800_0000, 1'b1, 1'b1, 4'd5, 9'h080, 11'h002, 4'h0, 4'd1, 3'b000);
    add_row(32'h9800_0000, 1'b1, 1'b1, 4'd6, 9'h002, 11'h004, 4'h0, 4'd0, 3'b000);
    // mul
    add_fetch(32'h7800_0000, 1'b0);
    add_row(32'h7800_0000, 1'b0, 1'b1, 4'd3, 9'h040, 11'h020, 4'h1, 4'd0, 3'b000);
    add_row(32'h7800_0000, 1'b0, 1'b1, 4'd4, 9'h040, 11'h002, 4'h2, 4'd10, 3'b000);
    add_row(32'h7800_0000, 1'b0, 1'b1, 4'd5, 9'h002, 11'h080, 4'h0, 4'd0, 3'b000);
    add_row(32'h7800_0000, 1'b0, 1'b1, 4'd6, 9'h004, 11'h040, 4'h0, 4'd0, 3'b000);
    // neg
    add_fetch(32'h8800_0000, 1'b0);
    add_row(32'h8800_0000, 1'b0, 1'b1, 4'd3, 9'h040, 11'h002, 4'h2, 4'd12, 3'b000);
    add_row(32'h8800_0000, 1'b0, 1'b1, 4'd4, 9'h002, 11'h100, 4'h1, 4'd0, 3'b000);
    // jal
    add_fetch(32'hA800_0000, 1'b0);
    add_row(32'hA800_0000, 1'b0, 1'b1, 4'd3, 9'h001, 11'h100, 4'h2, 4'd0, 3'b000);
    add_row(32'hA800_0000, 1'b0, 1'b1, 4'd4, 9'h040, 11'h004, 4'h1, 4'd0, 3'b000);
    // addi
    add_fetch(32'h6000_0000, 1'b0);
    add_row(32'h6000_0000, 1'b0, 1'b1, 4'd3, 9'h040, 11'h020, 4'h2, 4'd0, 3'b000);
    add_row(32'h6000_0000, 1'b0, 1'b1, 4'd4, 9'h080, 11'h002, 4'h0, 4'd1, 3'b000);
    add_row(32'h6000_0000, 1'b0, 1'b1, 4'd5, 9'h002, 11'h100, 4'h1, 4'd0, 3'b000);
    // in, mfhi, nop, unknown opcode 30
    add_fetch(32'hB000_0000, 1'b0);
    add_row(32'hB000_0000, 1'b0, 1'b1, 4'd3, 9'h100, 11'h100, 4'h1, 4'd0, 3'b000);
    add_fetch(32'hC000_0000, 1'b0);
    add_row(32'hC000_0000, 1'b0, 1'b1, 4'd3, 9'h010, 11'h100, 4'h1, 4'd0, 3'b000);
    add_fetch(32'hD000_0000, 1'b0);
    add_fetch(32'hF000_0000, 1'b0);

    // reset state
    repeat (2) @(posedge Clock);
    @(negedge Clock); #1;
    check("reset", obs(), {4'hF, 33'h0});
    Clear = 1'b0;

    // vector table
    foreach (vecs[i]) begin
      @(negedge Clock);
      drive(vecs[i].ir, vecs[i].con, vecs[i].mrdy);
      exp_q.push_back(vecs[i].exp);
      #1;
      check($sformatf("row%0d", i), obs(), exp_q.pop_front());
    end

    // memory timeout in T1
    @(negedge Clock);
    drive(32'hD000_0000, 1'b0, 1'b1);
    #1;
    check("tmo_t0", {33'h0, bus.TState}, 37'd0);
    @(negedge Clock);
    bus.MemReady = 1'b0;
    #1;
    len = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge Clock); #1;
      if (bus.TState != 4'd1) break;
      len++;
    end
    check("tmo_cycles", 37'(len), 37'd16);
    check("tmo_halt", obs(), {4'hE, 32'h0, 1'b1});
    bus.MemReady = 1'b1;
    repeat (3) @(negedge Clock);
    #1;
    check("tmo_stay", obs(), {4'hE, 32'h0, 1'b1});
    Clear = 1'b1;
    @(negedge Clock); #1;
    check("tmo_clear", obs(), {4'hF, 33'h0});
    Clear = 1'b0;
    @(negedge Clock); #1;
    check("tmo_restart", {33'h0, bus.TState}, 37'd0);

    // halt instruction
    bus.IR = 32'hD800_0000;
    repeat (3) @(negedge Clock);
    #1;
    check("halt_enter", obs(), {4'hE, 33'h0});
    repeat (3) @(negedge Clock);
    #1;
    check("halt_stay", obs(), {4'hE, 33'h0});
    Clear = 1'b1;
    @(negedge Clock); #1;
    Clear = 1'b0;
    @(negedge Clock); #1;
    check("halt_exit", {33'h0, bus.TState}, 37'd0);

    // Clear in the middle of add T4
    bus.IR = 32'h1800_0000;
    repeat (4) @(negedge Clock);
    #1;
    check("mid_t4", {33'h0, bus.TState}, 37'd4);
    Clear = 1'b1;
    @(negedge Clock); #1;
    check("mid_clear", obs(), {4'hF, 33'h0});
    Clear = 1'b0;
    @(negedge Clock); #1;
    check("mid_t0", {33'h0, bus.TState}, 37'd0);

    // random opcodes: step count and bus/memory exclusivity
    for (int i = 0; i < 200; i++) begin
      r_op = 5'($urandom_range(0, 31));
      if (r_op == 5'd27) r_op = 5'd26;
      bus.IR  = {r_op, 27'($urandom)};
      bus.CON = 1'($urandom_range(0, 1));
      exp_q.push_back(37'(exp_len(r_op)));
      len  = 1;
      viol = (($countones(bus.BusSel) > 1) || (bus.Read && bus.Write)) ? 1 : 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge Clock); #1;
        if (bus.TState == 4'd0) break;
        len++;
        if (($countones(bus.BusSel) > 1) || (bus.Read && bus.Write)) viol++;
      end
      check($sformatf("rand%0d_len_op%0d", i, r_op), 37'(len), exp_q.pop_front());
      check($sformatf("rand%0d_excl", i), 37'(viol), 37'd0);
    end

`ifdef SINGLE_STEP_EN
    // single-step: no StepEn, no movement
    bus.IR     = 32'hD000_0000;
    bus.StepEn = 1'b0;
    ts_hold    = bus.TState;
    repeat (3) @(negedge Clock);
    #1;
    check("step_hold", {33'h0, bus.TState}, {33'h0, ts_hold});
    bus.StepEn = 1'b1;
    @(negedge Clock); #1;
    check("step_adv", {33'h0, bus.TState}, {33'h0, ts_hold + 4'd1});
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
